lfsr_rand_range: RTL and testbench



---
 rtl/rand_pkg.sv | 23 ++
 rtl/lfsr_core.sv | 45 ++++
 rtl/lfsr_rand_range.sv | 167 ++++++++++++++++
 tb/tb_lfsr_rand_range.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_pkg.sv
// Shared definitions for the random delay generator.
//   state_t      : draw FSM states
//   MODE_*       : out-of-range handling selectors
//   TAPS_*       : maximal-length feedback masks for common widths,
//                  used with a left-shifting Fibonacci LFSR
package rand_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    DONE
  } state_t;

  localparam int unsigned MODE_CLAMP  = 0;
  localparam int unsigned MODE_REJECT = 1;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [23:0] TAPS_24 = 24'hE10000;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register.
// Ports:
//   clk    : rising-edge clock
//   areset : synchronous active-high reset, loads RESET_SEED
//   load   : load seed (an all-zero seed is replaced by RESET_SEED)
//   seed   : value for load
//   shift  : advance the register by one step
//   state  : current register contents
// Priority is areset > load > shift.
module lfsr_core
  import rand_pkg::*;
#(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS       = TAPS_16,
  parameter logic [WIDTH-1:0] RESET_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             shift,
  output logic [WIDTH-1:0] state
);

  logic feedback;

  assign feedback = ^(state & TAPS);

  // An all-zero state would lock the LFSR forever, so a shift out of it
  // reloads the reset seed instead.
  always_ff @(posedge clk) begin
    if (areset) begin
      state <= RESET_SEED;
    end else if (load) begin
      state <= (seed == '0) ? RESET_SEED : seed;
    end else if (shift) begin
      if (state == '0) begin
        state <= RESET_SEED;
      end else begin
        state <= {state[WIDTH-2:0], feedback};
      end
    end
  end

endmodule

// File: rtl/lfsr_rand_range.sv
// Pseudo-random delay generator: LFSR draws mapped into [MIN_VAL, MAX_VAL].
// Ports:
//   clk       : rising-edge clock
//   areset    : synchronous active-high reset
//   seed_load : load seed into the LFSR, aborting any draw in progress
//   seed      : seed value (zero is replaced by RESET_SEED)
//   req       : request a draw, taken only while idle
//   busy      : draw in progress
//   valid     : one-cycle pulse, rnd holds a new draw
//   rnd       : last drawn value, held until the next valid
//   clamped   : last draw was forced to a bound
module lfsr_rand_range
  import rand_pkg::*;
#(
  parameter int unsigned      WIDTH           = 16,
  parameter logic [WIDTH-1:0] TAPS            = TAPS_16,
  parameter logic [WIDTH-1:0] RESET_SEED      = 16'hACE1,
  parameter int unsigned      MIN_VAL         = 2000,
  parameter int unsigned      MAX_VAL         = 15000,
  parameter int unsigned      SHIFTS_PER_DRAW = 16,
  parameter int unsigned      MODE            = MODE_CLAMP,
  parameter int unsigned      MAX_RETRY       = 3,
  parameter int unsigned      FREE_RUN        = 1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] rnd,
  output logic             clamped
);

  localparam int unsigned CW = (SHIFTS_PER_DRAW > 1) ? $clog2(SHIFTS_PER_DRAW) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0]    CNT_INIT    = CW'(SHIFTS_PER_DRAW - 1);
  localparam logic [RW-1:0]    RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [WIDTH-1:0] MIN_W       = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W       = WIDTH'(MAX_VAL);

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_rand_range: WIDTH must be in 4..32");
  end
  if (RESET_SEED == '0) begin : g_bad_seed
    $error("lfsr_rand_range: RESET_SEED must be nonzero");
  end
  if (MIN_VAL > MAX_VAL) begin : g_bad_bounds
    $error("lfsr_rand_range: MIN_VAL must not exceed MAX_VAL");
  end
  if (64'(MAX_VAL) >= (64'd1 << WIDTH)) begin : g_bad_max
    $error("lfsr_rand_range: MAX_VAL must fit in WIDTH bits");
  end
  if (SHIFTS_PER_DRAW < 1) begin : g_bad_shifts
    $error("lfsr_rand_range: SHIFTS_PER_DRAW must be at least 1");
  end
  if (MODE != MODE_CLAMP && MODE != MODE_REJECT) begin : g_bad_mode
    $error("lfsr_rand_range: MODE must be 0 or 1");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic [RW-1:0]    retry;
  logic [WIDTH-1:0] lfsr_state;
  logic             shift_en;
  logic             below_min, above_max, in_range, can_retry;

  lfsr_core #(
    .WIDTH     (WIDTH),
    .TAPS      (TAPS),
    .RESET_SEED(RESET_SEED)
  ) u_lfsr (
    .clk   (clk),
    .areset(areset),
    .load  (seed_load),
    .seed  (seed),
    .shift (shift_en),
    .state (lfsr_state)
  );

  // A bound sitting at the edge of the representable range can never be
  // crossed, so that side of the range test is tied off.
  if (MIN_VAL == 0) begin : g_no_min
    assign below_min = 1'b0;
  end else begin : g_min
    assign below_min = lfsr_state < MIN_W;
  end
  if (64'(MAX_VAL) == (64'd1 << WIDTH) - 64'd1) begin : g_no_max
    assign above_max = 1'b0;
  end else begin : g_max
    assign above_max = lfsr_state > MAX_W;
  end

  assign in_range  = !below_min && !above_max;
  assign can_retry = (MODE == MODE_REJECT) && (retry < RETRY_LIMIT);

  // Next-state logic; the LFSR only moves while idle (free-running) or
  // during the shift phase, never while checking or presenting a result.
  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        shift_en = (FREE_RUN != 0);
        if (req) state_d = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == '0) state_d = CHECK;
      end
      CHECK: begin
        state_d = (in_range || !can_retry) ? DONE : SHIFT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus the shift/retry counters and the result registers.
  // seed_load abandons a draw but keeps the previous result visible.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= IDLE;
      cnt     <= '0;
      retry   <= '0;
      rnd     <= MIN_W;
      clamped <= 1'b0;
    end else if (seed_load) begin
      state_q <= IDLE;
      cnt     <= '0;
      retry   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            cnt   <= CNT_INIT;
            retry <= '0;
          end
        end
        SHIFT: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        CHECK: begin
          if (in_range) begin
            rnd     <= lfsr_state;
            clamped <= 1'b0;
          end else if (can_retry) begin
            retry <= retry + RW'(1);
            cnt   <= CNT_INIT;
          end else begin
            rnd     <= below_min ? MIN_W : MAX_W;
            clamped <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q == SHIFT) || (state_q == CHECK);
  assign valid = (state_q == DONE);

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Testbench for lfsr_rand_range: five configurations share one stimulus
// stream; a draw-level model predicts busy/valid/rnd/clamped every cycle.
module tb_lfsr_rand_range;

  localparam int NI = 5;
  // 0: defaults  1: S=1 no free-run  2: reject mode S=1  3: full range S=1
  // 4: full range S=4 free-running
  localparam int unsigned C_MIN   [NI] = '{2000, 2000, 2000, 0, 0};
  localparam int unsigned C_MAX   [NI] = '{15000, 15000, 15000, 65535, 65535};
  localparam int unsigned C_S     [NI] = '{16, 1, 1, 1, 4};
  localparam int unsigned C_MODE  [NI] = '{0, 0, 1, 0, 0};
  localparam int unsigned C_RETRY [NI] = '{3, 3, 3, 3, 3};
  localparam int unsigned C_FR    [NI] = '{1, 0, 0, 0, 1};

  localparam int P_IDLE = 0;
  localparam int P_BUSY = 1;
  localparam int P_DONE = 2;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic seed_load = 1'b0;
  logic req = 1'b0;
  logic [15:0] seed = '0;
  logic [NI-1:0] busy_v, valid_v, clamped_v;
  logic [15:0] rnd_v [NI];

  int total = 0;
  int bad = 0;
  bit live = 1'b0;

  int unsigned m_lfsr [NI];
  int unsigned m_phase [NI];
  int unsigned m_left [NI];
  int unsigned m_rnd [NI];
  int unsigned m_res [NI];
  bit m_clamped [NI];
  bit m_resc [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    lfsr_rand_range #(
      .WIDTH          (16),
      .TAPS           (16'hB400),
      .RESET_SEED     (16'hACE1),
      .MIN_VAL        (C_MIN[g]),
      .MAX_VAL        (C_MAX[g]),
      .SHIFTS_PER_DRAW(C_S[g]),
      .MODE           (C_MODE[g]),
      .MAX_RETRY      (C_RETRY[g]),
      .FREE_RUN       (C_FR[g])
    ) u_dut (
      .clk      (clk),
      .areset   (areset),
      .seed_load(seed_load),
      .seed     (seed),
      .req      (req),
      .busy     (busy_v[g]),
      .valid    (valid_v[g]),
      .rnd      (rnd_v[g]),
      .clamped  (clamped_v[g])
    );
  end

  function automatic int unsigned shift1(int unsigned x);
    int unsigned fb;
    if (x == 0) return 32'hACE1;
    fb = $countones(x & 32'hB400) % 2;
    return ((x << 1) | fb) & 32'hFFFF;
  endfunction

  // Whole draw computed at acceptance: result, clamp flag, attempt count.
  task automatic draw(input int i, inout int unsigned x, output int unsigned res,
                      output bit clp, output int unsigned att);
    bit fin;
    fin = 1'b0;
    att = 0;
    res = 0;
    clp = 1'b0;
    while (!fin) begin
      att++;
      for (int k = 0; k < int'(C_S[i]); k++) x = shift1(x);
      if (x >= C_MIN[i] && x <= C_MAX[i]) begin
        res = x;
        clp = 1'b0;
        fin = 1'b1;
      end else if (C_MODE[i] == 0 || att == C_RETRY[i] + 1) begin
        res = (x < C_MIN[i]) ? C_MIN[i] : C_MAX[i];
        clp = 1'b1;
        fin = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int unsigned x, res, att;
      bit clp;
      if (areset) begin
        m_lfsr[i] = 32'hACE1;
        m_rnd[i] = C_MIN[i];
        m_clamped[i] = 1'b0;
        m_phase[i] = P_IDLE;
      end else if (seed_load) begin
        m_lfsr[i] = (seed == 16'h0) ? 32'hACE1 : 32'(seed);
        m_phase[i] = P_IDLE;
      end else if (m_phase[i] == P_IDLE) begin
        if (C_FR[i] != 0) m_lfsr[i] = shift1(m_lfsr[i]);
        if (req) begin
          x = m_lfsr[i];
          draw(i, x, res, clp, att);
          m_lfsr[i] = x;
          m_res[i] = res;
          m_resc[i] = clp;
          m_left[i] = (C_S[i] + 1) * att;
          m_phase[i] = P_BUSY;
        end
      end else if (m_phase[i] == P_BUSY) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_phase[i] = P_DONE;
          m_rnd[i] = m_res[i];
          m_clamped[i] = m_resc[i];
        end
      end else begin
        m_phase[i] = P_IDLE;
      end
    end
    if (areset) live = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      for (int i = 0; i < NI; i++) begin
        checkOutput($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_phase[i] == P_BUSY));
        checkOutput($sformatf("valid[%0d]", i), 32'(valid_v[i]), 32'(m_phase[i] == P_DONE));
        checkOutput($sformatf("rnd[%0d]", i), 32'(rnd_v[i]), m_rnd[i]);
        checkOutput($sformatf("clamped[%0d]", i), 32'(clamped_v[i]), 32'(m_clamped[i]));
      end
    end
  end

  // One cycle of stimulus: drive at a falling edge, return at the next one.
  task automatic applyStimulus(input logic rst, input logic ld, input logic [15:0] sd,
                               input logic rq);
    areset = rst;
    seed_load = ld;
    seed = sd;
    req = rq;
    @(negedge clk);
  endtask

  // Called just after the req cycle; n counts falling edges after the req edge.
  task automatic waitValid(input int idx, output bit seen, output int n);
    seen = 1'b0;
    n = 1;
    while (!seen && n <= 400) begin
      if (valid_v[idx] === 1'b1) seen = 1'b1;
      else begin
        applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
        n++;
      end
    end
  endtask

  task automatic literalDraw(input string name, input int idx, input logic [15:0] sd,
                             input int unsigned exp_rnd, input bit exp_clp, input int exp_lat);
    bit seen;
    int n;
    applyStimulus(1'b0, 1'b1, sd, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    waitValid(idx, seen, n);
    checkOutput({name, "_seen"}, 32'(seen), 32'd1);
    checkOutput({name, "_rnd"}, 32'(rnd_v[idx]), exp_rnd);
    checkOutput({name, "_clamped"}, 32'(clamped_v[idx]), 32'(exp_clp));
    checkOutput({name, "_latency"}, 32'(n), 32'(exp_lat));
    repeat (25) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    bit seen;
    int n, vcount;
    logic [15:0] r1, r2;

    repeat (3) @(negedge clk);
    checkOutput("reset_rnd0", 32'(rnd_v[0]), 32'd2000);
    checkOutput("reset_rnd3", 32'(rnd_v[3]), 32'd0);
    checkOutput("reset_busy", 32'(busy_v), 32'd0);
    checkOutput("reset_valid", 32'(valid_v), 32'd0);
    checkOutput("reset_clamped", 32'(clamped_v), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

    literalDraw("full_seed1", 3, 16'h0001, 32'h0002, 1'b0, 3);
    literalDraw("def_1000", 1, 16'h1000, 32'd8193, 1'b0, 3);
    literalDraw("def_4000", 1, 16'h4000, 32'd15000, 1'b1, 3);
    literalDraw("def_8000", 1, 16'h8000, 32'd2000, 1'b1, 3);
    literalDraw("rej_8000", 2, 16'h8000, 32'd2000, 1'b1, 9);
    literalDraw("zero_full", 3, 16'h0000, 32'h59C3, 1'b0, 3);
    literalDraw("zero_def", 1, 16'h0000, 32'd15000, 1'b1, 3);

    // Abort a long draw with seed_load part-way through the shifting.
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    checkOutput("abort_busy_before", 32'(busy_v[0]), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0);
    checkOutput("abort_busy_after", 32'(busy_v[0]), 32'd0);
    vcount = 0;
    repeat (30) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
      if (valid_v[0] === 1'b1) vcount++;
    end
    checkOutput("abort_no_valid", 32'(vcount), 32'd0);
    checkOutput("abort_rnd_kept", 32'(rnd_v[0]), 32'd15000);

    // A second req while busy must not queue another draw.
    vcount = 0;
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (valid_v[0] === 1'b1) vcount++;
      applyStimulus(1'b0, 1'b0, 16'h0, (c == 3) ? 1'b1 : 1'b0);
    end
    checkOutput("busy_req_one_valid", 32'(vcount), 32'd1);

    // Reset while the S=1 instance is checking its result.
    applyStimulus(1'b0, 1'b1, 16'h4000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    checkOutput("chk_busy", 32'(busy_v[1]), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("chk_reset_rnd", 32'(rnd_v[1]), 32'd2000);
    checkOutput("chk_reset_busy", 32'(busy_v[1]), 32'd0);
    checkOutput("chk_reset_valid", 32'(valid_v[1]), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

    // Free-running: same seed, different idle gaps, different results.
    applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    waitValid(4, seen, n);
    checkOutput("gap_a_seen", 32'(seen), 32'd1);
    r1 = rnd_v[4];
    repeat (25) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
    waitValid(4, seen, n);
    checkOutput("gap_b_seen", 32'(seen), 32'd1);
    r2 = rnd_v[4];
    checkOutput("gap_differs", 32'(r1 != r2), 32'd1);
    repeat (25) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 29) == 0,
                    ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                    $urandom_range(0, 3) == 0);
    end
    repeat (40) applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
